// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory read arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_read_arb_if.sv
// Requester-side and memory-side read bus of the arbiter; slave is the arbiter view.
interface mem_read_arb_if;
  import mem_arb_pkg::*;

  logic              if_req;
  logic              dm_req;
  logic [ADDR_W-1:0] if_addr;
  logic [ADDR_W-1:0] dm_addr;
  logic              if_ack;
  logic              dm_ack;
  logic              if_rvalid;
  logic              dm_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_rreq;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_data_valid;

  modport slave (
    input  if_req, dm_req, if_addr, dm_addr, mem_rdata, mem_data_valid,
    output if_ack, dm_ack, if_rvalid, dm_rvalid, if_rdata, dm_rdata,
           mem_rreq, mem_raddr
  );

  modport master (
    output if_req, dm_req, if_addr, dm_addr, mem_rdata, mem_data_valid,
    input  if_ack, dm_ack, if_rvalid, dm_rvalid, if_rdata, dm_rdata,
           mem_rreq, mem_raddr
  );

endinterface

// File: rtl/mem_read_arb_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the favoured port and moves on enable.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = (ptr_q == PORT_DM) ? 2'b10 : 2'b01;
    end
    ptr_d = ptr_q;
    // After a grant, favour whichever port lost (or did not ask).
    if (en_i && (gnt_o != 2'b00)) begin
      ptr_d = gnt_o[PORT_IF] ? PORT_DM : PORT_IF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= PORT_IF;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_read_arb.sv
// Round-robin read arbiter between instruction-fetch and data ports onto one memory.
// Optional MEM_ARB_PERF_EN adds grant and busy-cycle performance counters.
module mem_read_arb
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mem_read_arb_if.slave     bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_dm_grants,
  output logic [31:0]       perf_busy_cycles
`endif
);

  // state | meaning
  // IDLE  | arbitrate pending requests, ack the winner, latch its address
  // BUSY  | memory request outstanding, wait for mem_data_valid
  // RESP  | one-cycle rvalid pulse on the granted port

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              gnt_id_q, gnt_id_d;
  logic [1:0]        req_vec;
  logic [1:0]        gnt_vec;
  logic              arb_en;

  // Requests are masked while reset is held so no ack can leak out combinationally.
  assign req_vec = {bus.dm_req, bus.if_req} & {2{~reset}};

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .req_i (req_vec),
    .en_i  (arb_en),
    .gnt_o (gnt_vec)
  );

  assign bus.mem_raddr = addr_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rdata_d       = rdata_q;
    gnt_id_d      = gnt_id_q;
    arb_en        = 1'b0;
    bus.if_ack    = 1'b0;
    bus.dm_ack    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.dm_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.dm_rdata  = '0;
    bus.mem_rreq  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_vec != 2'b00) begin
          arb_en     = 1'b1;
          bus.if_ack = gnt_vec[PORT_IF];
          bus.dm_ack = gnt_vec[PORT_DM];
          gnt_id_d   = gnt_vec[PORT_DM] ? PORT_DM : PORT_IF;
          addr_d     = gnt_vec[PORT_DM] ? bus.dm_addr : bus.if_addr;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        bus.mem_rreq = 1'b1;
        if (bus.mem_data_valid) begin
          rdata_d = bus.mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        if (gnt_id_q == PORT_DM) begin
          bus.dm_rvalid = 1'b1;
          bus.dm_rdata  = rdata_q;
        end else begin
          bus.if_rvalid = 1'b1;
          bus.if_rdata  = rdata_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rdata_q  <= '0;
      gnt_id_q <= PORT_IF;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rdata_q  <= rdata_d;
      gnt_id_q <= gnt_id_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_dm_q, perf_busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_if_q   <= '0;
      perf_dm_q   <= '0;
      perf_busy_q <= '0;
    end else begin
      if (arb_en && gnt_vec[PORT_IF]) perf_if_q <= perf_if_q + 32'd1;
      if (arb_en && gnt_vec[PORT_DM]) perf_dm_q <= perf_dm_q + 32'd1;
      if (state_q == BUSY)            perf_busy_q <= perf_busy_q + 32'd1;
    end
  end

  assign perf_if_grants   = perf_if_q;
  assign perf_dm_grants   = perf_dm_q;
  assign perf_busy_cycles = perf_busy_q;
`endif

endmodule

// File: tb/tb_mem_read_arb.sv
// Scoreboard bench for mem_read_arb: directed scenarios plus randomized two-port traffic.
module tb_mem_read_arb;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_read_arb_if bus();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_grants, perf_dm_grants, perf_busy_cycles;
`endif

  mem_read_arb dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_if_grants   (perf_if_grants),
    .perf_dm_grants   (perf_dm_grants),
    .perf_busy_cycles (perf_busy_cycles)
`endif
  );

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          mem_delay = 0;
  logic        spur = 1'b0;
  int          mcnt;
  // reference model state
  logic        m_ptr = 1'b0;
  int          free_at = 0;
  int          busy_lo = 1;
  int          busy_hi = 0;
  logic [31:0] last_addr = '0;
  int          m_if_g = 0, m_dm_g = 0, m_busy = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // memory: answers D+2 cycles into an outstanding request
  always @(posedge clk or posedge reset) begin
    if (reset) mcnt <= 0;
    else if (bus.mem_rreq && !bus.mem_data_valid) mcnt <= mcnt + 1;
    else mcnt <= 0;
  end
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.mem_data_valid = spur | (bus.mem_rreq && (mcnt == mem_delay + 1));
  assign bus.mem_rdata = !bus.mem_data_valid ? 32'h0 :
                         (spur ? 32'hBAD0BAD0 : mem_f(bus.mem_raddr));

  // monitor + reference model
  initial begin : monitor
    logic [1:0]  reqv, exp_ack;
    logic        g, busy;
    logic [31:0] a;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("reset_ctl", {bus.if_ack, bus.dm_ack, bus.if_rvalid, bus.dm_rvalid, bus.mem_rreq}, 64'h0);
        chk("reset_rdata", {bus.if_rdata, bus.dm_rdata}, 64'h0);
        sb.delete();
        m_ptr = 1'b0; free_at = 0; busy_lo = 1; busy_hi = 0; last_addr = '0;
        m_if_g = 0; m_dm_g = 0; m_busy = 0;
      end else begin
        chk("mem_raddr", bus.mem_raddr, last_addr);
        reqv = {bus.dm_req, bus.if_req};
        exp_ack = 2'b00;
        if (cyc >= free_at && reqv != 2'b00) begin
          g = (reqv == 2'b11) ? m_ptr : reqv[1];
          exp_ack = g ? 2'b10 : 2'b01;
          m_ptr = ~g;
          a = g ? bus.dm_addr : bus.if_addr;
          e.port = g; e.data = mem_f(a); e.due = cyc + 3 + mem_delay;
          sb.push_back(e);
          free_at = cyc + 4 + mem_delay;
          busy_lo = cyc + 1; busy_hi = cyc + 2 + mem_delay;
          last_addr = a;
          if (g) m_dm_g++; else m_if_g++;
        end
        chk("ack", {bus.dm_ack, bus.if_ack}, exp_ack);
        busy = (cyc >= busy_lo) && (cyc <= busy_hi);
        if (busy) m_busy++;
        chk("mem_rreq", bus.mem_rreq, busy);
        if (bus.if_rvalid || bus.dm_rvalid) begin
          if (sb.size() == 0) begin
            chk("unexpected_rvalid", {bus.dm_rvalid, bus.if_rvalid}, 64'h0);
          end else begin
            e = sb.pop_front();
            chk("rvalid_port", {bus.dm_rvalid, bus.if_rvalid}, e.port ? 2'b10 : 2'b01);
            chk("rdata", e.port ? bus.dm_rdata : bus.if_rdata, e.data);
            chk("rvalid_cycle", cyc, e.due);
          end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          chk("missing_rvalid", {bus.dm_rvalid, bus.if_rvalid}, e.port ? 2'b10 : 2'b01);
        end
        if (!bus.if_rvalid) chk("if_rdata_zero", bus.if_rdata, 64'h0);
        if (!bus.dm_rvalid) chk("dm_rdata_zero", bus.dm_rdata, 64'h0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 with the request dropped.
  task automatic do_req(input int p, input logic [31:0] a, input int wd,
                        output int t, output bit acked);
    acked = 1'b0;
    t = -1;
    if (p == 0) begin bus.if_addr = a; bus.if_req = 1'b1; end
    else        begin bus.dm_addr = a; bus.dm_req = 1'b1; end
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if ((p == 0) ? bus.if_ack : bus.dm_ack) begin
        acked = 1'b1;
        t = cyc;
        break;
      end
      @(posedge clk); #1;
      if (w == wd) break;
    end
    if (acked) begin @(posedge clk); #1; end
    else if (wd < 0) chk("ack_timeout", acked, 64'h1);
    if (p == 0) bus.if_req = 1'b0; else bus.dm_req = 1'b0;
  endtask

  task automatic wait_rv(input int p, output int t, output logic [31:0] d);
    t = -1;
    d = '0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if ((p == 0) ? bus.if_rvalid : bus.dm_rvalid) begin
        t = cyc;
        d = (p == 0) ? bus.if_rdata : bus.dm_rdata;
        break;
      end
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || cyc < free_at) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d responses still pending", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    spur = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    int t, wd;
    bit ok;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      wd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
      do_req(p, $urandom(), wd, t, ok);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int t, r, k;
    bit ok;
    logic [31:0] d;
    logic [3:0] order;

    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    bus.if_addr = '0;  bus.dm_addr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // single IF read at zero memory delay
    mem_delay = 0;
    do_req(0, 32'h10, -1, t, ok);
    wait_rv(0, r, d);
    chk("if_latency_d0", r - t, 64'd3);
    chk("if_rdata_d0", d, 32'hDEADBEEF);
    drain();

    // both ports held high from reset release
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.if_addr = 32'h4; bus.dm_addr = 32'h8;
    bus.if_req = 1'b1;   bus.dm_req = 1'b1;
    reset = 1'b0;
    k = 0;
    order = '0;
    for (int w = 0; w < 60 && k < 4; w++) begin
      @(negedge clk);
      if (bus.if_ack || bus.dm_ack) begin
        order[k] = bus.dm_ack;
        k++;
      end
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    chk("rr_order", order, 4'b1010);
    drain();

    // long memory delay, IF request arriving mid-BUSY
    mem_delay = 20;
    do_req(1, 32'h100, -1, t, ok);
    repeat (4) @(posedge clk);
    #1;
    bus.if_addr = 32'h200; bus.if_req = 1'b1;
    wait_rv(1, r, d);
    chk("dm_latency_d20", r - t, 64'd23);
    chk("dm_rdata_d20", d, mem_f(32'h100));
    k = -1;
    for (int w = 0; w < 10; w++) begin
      @(negedge clk);
      if (bus.if_ack) begin k = cyc; break; end
    end
    chk("if_ack_next_idle", k, r + 1);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    drain();

    // spurious mem_data_valid while idle
    spur = 1'b1;
    repeat (2) @(posedge clk);
    #1 spur = 1'b0;
    mem_delay = 2;
    do_req(1, 32'h500, -1, t, ok);
    wait_rv(1, r, d);
    chk("latency_after_spur", r - t, 64'd5);
    drain();

    // reset in the middle of BUSY after an IF grant
    mem_delay = 20;
    do_req(0, 32'h300, -1, t, ok);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_ctl", {bus.if_ack, bus.dm_ack, bus.if_rvalid, bus.dm_rvalid, bus.mem_rreq}, 64'h0);
    chk("rst_async_raddr", bus.mem_raddr, 64'h0);
    chk("rst_async_rdata", {bus.if_rdata, bus.dm_rdata}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    mem_delay = 0;
    bus.if_addr = 32'h40; bus.dm_addr = 32'h44;
    bus.if_req = 1'b1;    bus.dm_req = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_grant", {bus.dm_ack, bus.if_ack}, 2'b01);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (bus.dm_ack) break;
    end
    @(posedge clk); #1;
    bus.dm_req = 1'b0;
    drain();

    // 3 IF + 2 DM at zero delay from a clean reset
    do_reset();
    mem_delay = 0;
    for (int i = 0; i < 5; i++) begin
      do_req(i % 2, 32'h1000 + 32'(i * 4), -1, t, ok);
      drain();
    end
`ifdef MEM_ARB_PERF_EN
    chk("perf_if_3", perf_if_grants, 64'd3);
    chk("perf_dm_2", perf_dm_grants, 64'd2);
    chk("perf_busy_10", perf_busy_cycles, 64'd10);
`endif

    // randomized two-port traffic with random memory delay per batch
    for (int b = 0; b < 8; b++) begin
      mem_delay = $urandom_range(0, 6);
      fork
        rand_port(0, 5);
        rand_port(1, 5);
      join
      drain();
    end

`ifdef MEM_ARB_PERF_EN
    chk("perf_if_model", perf_if_grants, m_if_g);
    chk("perf_dm_model", perf_dm_grants, m_dm_g);
    chk("perf_busy_model", perf_busy_cycles, m_busy);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_read_arb.md
MEM_READ_ARB -- requirements
Module: mem_read_arb

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: if_req, dm_req  input  1 each  read request from instruction-fetch (port 0) and data (port 1).
REQ-004 SHALL have ports: if_addr, dm_addr  input  32 each  word address; must be held stable while the matching req is high and ack is low.
REQ-005 SHALL have ports: if_ack, dm_ack  output  1 each  one-cycle request-accepted pulse.
REQ-006 SHALL have ports: if_rvalid, dm_rvalid  output  1 each  one-cycle response-valid pulse.
REQ-007 SHALL have ports: if_rdata, dm_rdata  output  32 each  response data; zero when the matching rvalid is low.
REQ-008 SHALL have ports: mem_rreq  output  1, mem_raddr  output  32  memory-side request and held address.
REQ-009 SHALL have ports: mem_rdata  input  32, mem_data_valid  input  1  memory-side response; mem_rdata valid only while mem_data_valid is high.

Function
REQ-010 SHALL implement states IDLE, BUSY, RESP.
REQ-011 IDLE: if any req high, SHALL grant one port, pulse its ack combinationally in that cycle, latch its address into addr_q, record grant id, and go to BUSY; else remain IDLE.
REQ-012 BUSY: SHALL drive mem_rreq=1, mem_raddr=addr_q; on mem_data_valid=1 SHALL capture mem_rdata into rdata_q and go to RESP.
REQ-013 RESP: SHALL drive mem_rreq=0, pulse rvalid with rdata=rdata_q on the granted port only, and return to IDLE.
REQ-014 mem_rreq SHALL be 0 in IDLE and RESP; mem_raddr SHALL be addr_q in all states.
REQ-015 Arbitration SHALL be round-robin: 1-bit priority pointer, port 0 favoured after reset; on a grant the pointer SHALL point to the non-granted port.
REQ-016 Single requester SHALL be granted regardless of pointer.
REQ-017 Latency from ack cycle to rvalid cycle SHALL be 3 + D cycles, D = memory delay (D=0 gives 3).
REQ-018 No new ack SHALL be issued in BUSY or RESP; pending reqs SHALL wait and be arbitrated in the next IDLE.
REQ-019 Requester may drop req after ack; deasserted req before ack SHALL be treated as withdrawn.
REQ-020 mem_data_valid in IDLE or RESP SHALL be ignored.
REQ-021 At most one request SHALL be outstanding to memory.

Reset
REQ-022 On reset: state=IDLE, pointer=port 0, addr_q=0, rdata_q=0, all acks/rvalids=0, mem_rreq=0, rdata outputs=0.
REQ-023 Reset mid-BUSY or mid-RESP SHALL abandon the transaction with no rvalid issued; the memory shares reset and returns to idle.

Configuration
REQ-024 Macro MEM_ARB_PERF_EN defined: SHALL add outputs perf_if_grants, perf_dm_grants, perf_busy_cycles (32 bits each), incremented on each port grant and each BUSY cycle, wrapping at 2^32, cleared by reset.
REQ-025 MEM_ARB_PERF_EN undefined: SHALL omit those ports and counters; all other behaviour identical.

Structure
REQ-026 Shared package mem_arb_pkg SHALL hold the state enum (IDLE/BUSY/RESP), port id constants (PORT_IF=0, PORT_DM=1), and address/data width parameters (32).
REQ-027 Round-robin grant logic SHALL be a sub-module rr_arb2 (2 requests, grant vector, pointer update on enable).

Verification
REQ-028 if_req=1, if_addr=0x10, mem delay 0, mem[0x10]=0xDEADBEEF -> if_ack in cycle T, if_rvalid=1, if_rdata=0xDEADBEEF in T+3, dm_* stay 0.
REQ-029 if_req and dm_req both held high from reset release, addrs 0x4/0x8 -> grant order IF, DM, IF, DM; each rvalid on the correct port with the correct data.
REQ-030 dm_req with memory delay 20 -> mem_rreq held high, mem_raddr stable for all of BUSY; dm_rvalid exactly at T+23; if_req raised mid-BUSY gets no ack until the next IDLE.
REQ-031 Reset asserted while BUSY -> all outputs 0 immediately; no rvalid ever for the abandoned request; next if_req after release is granted to port 0 first.
REQ-032 Spurious mem_data_valid=1 in IDLE -> no rvalid, no state change.
REQ-033 With MEM_ARB_PERF_EN: 3 IF and 2 DM transactions at delay 0 -> perf_if_grants=3, perf_dm_grants=2, perf_busy_cycles=10.
